// File: rtl/tl_mem_responder.sv
// TileLink manager-side responder backed by a flop-array scratchpad memory.
// Latency: first D beat one cycle after the A beat that completes a request; one beat per cycle.
// Backpressure: A is stalled (a_ready_o=0) while a response is pending; D holds on d_ready_i=0.
module tl_mem_responder #(
  parameter int DataWidth   = 64,
  parameter int AddrWidth   = 32,
  parameter int SourceWidth = 1,
  parameter int SinkWidth   = 1,
  parameter int Depth       = 256,
  parameter int MaxSize     = 6
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  // A channel
  input  logic                     a_valid_i,
  output logic                     a_ready_o,
  input  logic [2:0]               a_opcode_i,
  input  logic [2:0]               a_param_i,
  input  logic [2:0]               a_size_i,
  input  logic [SourceWidth-1:0]   a_source_i,
  input  logic [AddrWidth-1:0]     a_address_i,
  input  logic [DataWidth/8-1:0]   a_mask_i,
  input  logic                     a_corrupt_i,
  input  logic [DataWidth-1:0]     a_data_i,
  // D channel
  output logic                     d_valid_o,
  input  logic                     d_ready_i,
  output logic [2:0]               d_opcode_o,
  output logic [2:0]               d_param_o,
  output logic [2:0]               d_size_o,
  output logic [SourceWidth-1:0]   d_source_o,
  output logic [SinkWidth-1:0]     d_sink_o,
  output logic                     d_denied_o,
  output logic                     d_corrupt_o,
  output logic [DataWidth-1:0]     d_data_o
);

  localparam int BytesPerBeat = DataWidth / 8;
  localparam int LogBytes     = $clog2(BytesPerBeat);
  localparam int IdxW         = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int BeatW        = 8;
  localparam logic [AddrWidth:0] MemBytes = (AddrWidth+1)'(Depth * BytesPerBeat);

  typedef enum logic [2:0] {
    A_PUT_FULL    = 3'd0,
    A_PUT_PARTIAL = 3'd1,
    A_ARITHMETIC  = 3'd2,
    A_LOGICAL     = 3'd3,
    A_GET         = 3'd4,
    A_INTENT      = 3'd5,
    A_ACQ_BLOCK   = 3'd6,
    A_ACQ_PERM    = 3'd7
  } tl_a_op_e;

  typedef enum logic [2:0] {
    D_ACCESS_ACK      = 3'd0,
    D_ACCESS_ACK_DATA = 3'd1,
    D_HINT_ACK        = 3'd2,
    D_GRANT           = 3'd4,
    D_GRANT_DATA      = 3'd5,
    D_RELEASE_ACK     = 3'd6
  } tl_d_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PUT  = 2'd1,
    S_ACK  = 2'd2,
    S_READ = 2'd3
  } state_e;

  // Number of beats minus one for a given log2 transfer size.
  function automatic logic [BeatW-1:0] beats_m1(input logic [2:0] size);
    logic [BeatW-1:0] r;
    r = '0;
    if (int'(size) > LogBytes) begin
      r = BeatW'((1 << (int'(size) - LogBytes)) - 1);
    end
    return r;
  endfunction

  // Storage (not reset)
  logic [DataWidth-1:0] mem_q [Depth];

  // Transaction state
  state_e               state_q;
  logic                 a_ready_q;
  logic [2:0]           op_q;
  logic [AddrWidth-1:0] word_q;
  logic                 err_q;
  logic [BeatW-1:0]     beat_q;
  logic [BeatW-1:0]     last_q;

  // Registered D channel
  logic                   d_valid_q;
  logic [2:0]             d_opcode_q;
  logic [2:0]             d_size_q;
  logic [SourceWidth-1:0] d_source_q;
  logic                   d_denied_q;
  logic                   d_corrupt_q;
  logic [DataWidth-1:0]   d_data_q;

  // Request decode and datapath helpers
  logic [AddrWidth:0]   size_bytes;
  logic [AddrWidth:0]   last_byte;
  logic                 misaligned;
  logic                 req_err;
  logic [BeatW-1:0]     req_last;
  logic [AddrWidth-1:0] a_word;
  logic                 a_fire;
  logic                 in_put_phase;
  logic [2:0]           put_op;
  logic                 put_err;
  logic                 put_last;
  logic                 close_put;
  logic                 wr_en;
  logic [AddrWidth-1:0] wr_word;
  logic [IdxW-1:0]      wr_idx;
  logic [AddrWidth-1:0] rd_word;
  logic [IdxW-1:0]      rd_idx;
  logic [DataWidth-1:0] rd_dat;

  // a_param_i carries nothing this endpoint acts on.
  logic unused_a_param;
  assign unused_a_param = ^a_param_i;

  // a_ready drops immediately with reset even though the FSM register resets to IDLE.
  assign a_ready_o = a_ready_q & ~rst_i;
  assign a_fire    = a_valid_i & a_ready_o;

  // Legality of the request currently presented on A (used on the first beat only).
  always_comb begin
    size_bytes = (AddrWidth+1)'(1) << a_size_i;
    last_byte  = {1'b0, a_address_i} + size_bytes - (AddrWidth+1)'(1);
    misaligned = (a_address_i & (size_bytes[AddrWidth-1:0] - AddrWidth'(1))) != '0;
    req_err    = (int'(a_size_i) > MaxSize) || misaligned || (last_byte >= MemBytes);
    req_last   = beats_m1(a_size_i);
    a_word     = a_address_i >> LogBytes;
  end

  // Put-burst bookkeeping: first beat uses live A fields, later beats use latched ones.
  always_comb begin
    in_put_phase = (state_q == S_IDLE) || (state_q == S_PUT);
    put_op       = op_q;
    put_err      = err_q;
    put_last     = (beat_q == last_q);
    wr_word      = word_q + AddrWidth'(beat_q);
    if (state_q == S_IDLE) begin
      put_op   = a_opcode_i;
      put_err  = req_err;
      put_last = (req_last == '0);
      wr_word  = a_word;
    end
    close_put = a_fire && in_put_phase && !put_op[2] && put_last;
    wr_en     = a_fire && in_put_phase && !put_err && !a_corrupt_i &&
                ((put_op == A_PUT_FULL) || (put_op == A_PUT_PARTIAL));
    wr_idx    = IdxW'(wr_word);
  end

  // Read address: first word of a new Get, or the word after the current beat.
  always_comb begin
    rd_word = word_q + AddrWidth'(beat_q) + AddrWidth'(1);
    if (state_q == S_IDLE) begin
      rd_word = a_word;
    end
    rd_idx = IdxW'(rd_word);
    rd_dat = mem_q[rd_idx];
  end

  // Byte-lane masked memory write.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      for (int b = 0; b < BytesPerBeat; b++) begin
        if (a_mask_i[b]) begin
          mem_q[wr_idx][b*8 +: 8] <= a_data_i[b*8 +: 8];
        end
      end
    end
  end

  // Request/response FSM with registered A-ready and D outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      a_ready_q   <= 1'b1;
      op_q        <= '0;
      word_q      <= '0;
      err_q       <= 1'b0;
      beat_q      <= '0;
      last_q      <= '0;
      d_valid_q   <= 1'b0;
      d_opcode_q  <= '0;
      d_size_q    <= '0;
      d_source_q  <= '0;
      d_denied_q  <= 1'b0;
      d_corrupt_q <= 1'b0;
      d_data_q    <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (a_fire) begin
            op_q       <= a_opcode_i;
            word_q     <= a_word;
            err_q      <= req_err;
            last_q     <= req_last;
            beat_q     <= '0;
            d_size_q   <= a_size_i;
            d_source_q <= a_source_i;
            case (tl_a_op_e'(a_opcode_i))
              A_GET: begin
                state_q     <= S_READ;
                a_ready_q   <= 1'b0;
                d_valid_q   <= 1'b1;
                d_opcode_q  <= D_ACCESS_ACK_DATA;
                d_denied_q  <= req_err;
                d_corrupt_q <= req_err;
                d_data_q    <= req_err ? '0 : rd_dat;
              end
              A_PUT_FULL, A_PUT_PARTIAL, A_ARITHMETIC, A_LOGICAL: begin
                // Single-beat puts are finished by the close_put block below.
                state_q <= S_PUT;
                beat_q  <= BeatW'(1);
              end
              A_INTENT: begin
                state_q     <= S_ACK;
                a_ready_q   <= 1'b0;
                d_valid_q   <= 1'b1;
                d_opcode_q  <= D_HINT_ACK;
                d_denied_q  <= req_err;
                d_corrupt_q <= 1'b0;
                d_data_q    <= '0;
              end
              default: begin
                // Acquire: this endpoint holds no cache permissions to grant.
                state_q     <= S_ACK;
                a_ready_q   <= 1'b0;
                d_valid_q   <= 1'b1;
                d_opcode_q  <= D_ACCESS_ACK;
                d_denied_q  <= 1'b1;
                d_corrupt_q <= 1'b0;
                d_data_q    <= '0;
              end
            endcase
          end
        end
        S_PUT: begin
          if (a_fire) begin
            beat_q <= beat_q + BeatW'(1);
          end
        end
        S_ACK: begin
          if (d_ready_i) begin
            state_q   <= S_IDLE;
            a_ready_q <= 1'b1;
            d_valid_q <= 1'b0;
          end
        end
        S_READ: begin
          if (d_ready_i) begin
            if (beat_q == last_q) begin
              state_q   <= S_IDLE;
              a_ready_q <= 1'b1;
              d_valid_q <= 1'b0;
            end else begin
              beat_q   <= beat_q + BeatW'(1);
              d_data_q <= d_denied_q ? '0 : rd_dat;
            end
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase

      // Last beat of a put-like burst: overrides the per-state updates above.
      if (close_put) begin
        beat_q    <= '0;
        a_ready_q <= 1'b0;
        d_valid_q <= 1'b1;
        d_data_q  <= '0;
        if ((put_op == A_ARITHMETIC) || (put_op == A_LOGICAL)) begin
          // Atomics are not supported: answer with denied data beats.
          state_q     <= S_READ;
          d_opcode_q  <= D_ACCESS_ACK_DATA;
          d_denied_q  <= 1'b1;
          d_corrupt_q <= 1'b1;
        end else begin
          state_q     <= S_ACK;
          d_opcode_q  <= D_ACCESS_ACK;
          d_denied_q  <= put_err;
          d_corrupt_q <= 1'b0;
        end
      end
    end
  end

  assign d_valid_o   = d_valid_q;
  assign d_opcode_o  = d_opcode_q;
  assign d_param_o   = 3'd0;
  assign d_size_o    = d_size_q;
  assign d_source_o  = d_source_q;
  assign d_sink_o    = '0;
  assign d_denied_o  = d_denied_q;
  assign d_corrupt_o = d_corrupt_q;
  assign d_data_o    = d_data_q;

endmodule
